// File: rtl/pll_drp_sequencer.sv
// pll_drp_sequencer: PLL power-up and CLKOUT0 divide reconfiguration
// over DRP, with reset hold and lock supervision.
module pll_drp_sequencer #(
  parameter logic [6:0]  ADDR_REG1    = 7'h08,
  parameter logic [6:0]  ADDR_REG2    = 7'h09,
  parameter int unsigned RST_CYCLES   = 16,
  parameter int unsigned DRDY_TIMEOUT = 64,
  parameter int unsigned LOCK_TIMEOUT = 65536
) (
  input  logic        clk_i,
  input  logic        arst_n_i,
  input  logic        cfg_valid_i,
  output logic        cfg_ready_o,
  input  logic [7:0]  cfg_div_i,
  output logic        done_o,
  output logic [1:0]  err_o,
  output logic        clk_ok_o,
  output logic [6:0]  drp_daddr_o,
  output logic [15:0] drp_di_o,
  output logic        drp_den_o,
  output logic        drp_dwe_o,
  input  logic [15:0] drp_do_i,
  input  logic        drp_drdy_i,
  output logic        pll_rst_o,
  input  logic        pll_locked_i
);

  localparam int unsigned CW =
    $clog2(LOCK_TIMEOUT + RST_CYCLES + DRDY_TIMEOUT + 1);
  localparam logic [CW-1:0] RST_LAST  = CW'(RST_CYCLES - 1);
  localparam logic [CW-1:0] DRDY_LAST = CW'(DRDY_TIMEOUT - 1);
  localparam logic [CW-1:0] LOCK_LAST = CW'(LOCK_TIMEOUT - 1);

  localparam logic [1:0] E_OK   = 2'd0;
  localparam logic [1:0] E_DIV  = 2'd1;
  localparam logic [1:0] E_DRDY = 2'd2;
  localparam logic [1:0] E_LOCK = 2'd3;

  typedef enum logic [3:0] {
    S_BOOT_RST, S_BOOT_LOCK, S_IDLE,
    S_RD1, S_WR1, S_RD2, S_WR2,
    S_HOLD, S_WAIT_LOCK, S_REPORT
  } state_e;

  state_e        state_q, state_d, drp_next;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          issued_q, issued_d;
  logic [1:0]    err_q, err_d;
  logic [6:0]    div_q, div_d;
  logic [7:0]    rd_q, rd_d;
  logic          done_q, done_d;
  logic          ok_q;
  logic [1:0]    sync_q;
  logic          lock_s;
  logic          in_drp, is_wr, div_bad;
  logic          div_one, edge_b;
  logic [5:0]    hi, lo;
  logic [15:0]   reg1_w, reg2_w;
  logic          unused_do;

  assign lock_s    = sync_q[1];
  assign unused_do = ^drp_do_i[7:0];

  assign in_drp = (state_q == S_RD1) || (state_q == S_WR1)
               || (state_q == S_RD2) || (state_q == S_WR2);
  assign is_wr  = (state_q == S_WR1) || (state_q == S_WR2);

  assign drp_next = (state_q == S_RD1) ? S_WR1 :
                    (state_q == S_WR1) ? S_RD2 :
                    (state_q == S_RD2) ? S_WR2 : S_HOLD;

  assign div_bad = (cfg_div_i == 8'd0) || (cfg_div_i > 8'd126);

  // Divide 1 bypasses the counter, so its edge bit stays clear.
  assign div_one = (div_q == 7'd1);
  assign hi      = div_one ? 6'd1 : div_q[6:1];
  assign lo      = div_one ? 6'd1 : div_q[6:1] + {5'd0, div_q[0]};
  assign edge_b  = div_q[0] & ~div_one;
  assign reg1_w  = {rd_q[7:4], hi, lo};
  assign reg2_w  = {rd_q, edge_b, div_one, 6'd0};

  assign cfg_ready_o = (state_q == S_IDLE);
  assign done_o      = done_q;
  assign err_o       = err_q;
  assign clk_ok_o    = ok_q;
  assign drp_den_o   = in_drp & ~issued_q;
  assign drp_dwe_o   = drp_den_o & is_wr;
  assign drp_daddr_o = ((state_q == S_RD1) || (state_q == S_WR1)) ? ADDR_REG1 :
                       ((state_q == S_RD2) || (state_q == S_WR2)) ? ADDR_REG2 :
                       7'd0;
  assign drp_di_o    = (state_q == S_WR1) ? reg1_w :
                       (state_q == S_WR2) ? reg2_w : 16'd0;
  assign pll_rst_o   = (state_q == S_BOOT_RST) || in_drp
                    || (state_q == S_HOLD);

  // Two-flop synchronizer for the asynchronous LOCKED pin.
  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i) sync_q <= 2'b00;
    else           sync_q <= {sync_q[0], pll_locked_i};
  end

  // Sequencer next-state and bookkeeping.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    issued_d = issued_q;
    err_d    = err_q;
    div_d    = div_q;
    rd_d     = rd_q;
    done_d   = 1'b0;
    unique case (state_q)
      S_BOOT_RST, S_HOLD: begin
        if (cnt_q == RST_LAST) begin
          cnt_d   = '0;
          state_d = (state_q == S_HOLD) ? S_WAIT_LOCK : S_BOOT_LOCK;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_BOOT_LOCK, S_WAIT_LOCK: begin
        if (lock_s) begin
          cnt_d   = '0;
          state_d = (state_q == S_WAIT_LOCK) ? S_REPORT : S_IDLE;
        end else if (cnt_q == LOCK_LAST) begin
          cnt_d   = '0;
          err_d   = E_LOCK;
          state_d = (state_q == S_WAIT_LOCK) ? S_REPORT : S_IDLE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_IDLE: begin
        if (cfg_valid_i) begin
          div_d    = cfg_div_i[6:0];
          cnt_d    = '0;
          issued_d = 1'b0;
          err_d    = div_bad ? E_DIV : E_OK;
          state_d  = div_bad ? S_REPORT : S_RD1;
        end
      end
      S_RD1, S_WR1, S_RD2, S_WR2: begin
        if (!issued_q) begin
          issued_d = 1'b1;
          cnt_d    = '0;
        end else if (drp_drdy_i) begin
          issued_d = 1'b0;
          cnt_d    = '0;
          state_d  = drp_next;
          if (!is_wr) rd_d = drp_do_i[15:8];
        end else if (cnt_q == DRDY_LAST) begin
          issued_d = 1'b0;
          cnt_d    = '0;
          err_d    = E_DRDY;
          state_d  = S_HOLD;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_REPORT: begin
        if (!done_q) done_d  = 1'b1;
        else         state_d = S_IDLE;
      end
      default: state_d = S_BOOT_RST;
    endcase
  end

  // State registers; clk_ok looks at the state being entered.
  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i) begin
      state_q  <= S_BOOT_RST;
      cnt_q    <= '0;
      issued_q <= 1'b0;
      err_q    <= E_OK;
      div_q    <= '0;
      rd_q     <= '0;
      done_q   <= 1'b0;
      ok_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      issued_q <= issued_d;
      err_q    <= err_d;
      div_q    <= div_d;
      rd_q     <= rd_d;
      done_q   <= done_d;
      ok_q     <= lock_s & (state_d == S_IDLE);
    end
  end

endmodule

// File: tb/tb_pll_drp_sequencer.sv
// tb_pll_drp_sequencer: randomized requests against DRP/PLL models
// and a divider-encoding reference.
module tb_pll_drp_sequencer;

  logic        clk = 1'b0;
  logic        arst_n;
  logic        cfg_valid;
  logic        cfg_ready;
  logic [7:0]  cfg_div;
  logic        done;
  logic [1:0]  err;
  logic        clk_ok;
  logic [6:0]  daddr;
  logic [15:0] di;
  logic        den, dwe;
  logic [15:0] drp_do;
  logic        drdy;
  logic        pll_rst;
  logic        locked;

  always #5 clk = ~clk;

  pll_drp_sequencer dut (
    .clk_i        (clk),
    .arst_n_i     (arst_n),
    .cfg_valid_i  (cfg_valid),
    .cfg_ready_o  (cfg_ready),
    .cfg_div_i    (cfg_div),
    .done_o       (done),
    .err_o        (err),
    .clk_ok_o     (clk_ok),
    .drp_daddr_o  (daddr),
    .drp_di_o     (di),
    .drp_den_o    (den),
    .drp_dwe_o    (dwe),
    .drp_do_i     (drp_do),
    .drp_drdy_i   (drdy),
    .pll_rst_o    (pll_rst),
    .pll_locked_i (locked)
  );

  int n_chk  = 0;
  int n_pass = 0;
  int cyc    = 0;

  task automatic chk(input string tag, input int got, input int exp);
    n_chk++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // DRP slave model with random response latency
  logic [15:0] mem [0:127];
  bit          pend, pwe, drop_rd2;
  logic [6:0]  pa;
  logic [15:0] pd;
  int          lat_r, den_cnt, viol, rd2_den_t, last_drdy_t;
  logic [6:0]  wq_a [$];
  logic [15:0] wq_d [$];

  always @(negedge clk) begin
    if (!arst_n) begin
      pend = 1'b0;
      drdy = 1'b0;
    end else begin
      if (drdy) drdy = 1'b0;
      if (pend) begin
        if (den || daddr != pa || di != pd) viol++;
        if (lat_r == 0) begin
          drdy = 1'b1;
          if (!pwe) drp_do = mem[pa];
          pend = 1'b0;
          last_drdy_t = cyc;
        end else begin
          lat_r--;
        end
      end else if (den) begin
        den_cnt++;
        pa  = daddr;
        pd  = di;
        pwe = dwe;
        if (pwe) begin
          mem[pa] = pd;
          wq_a.push_back(pa);
          wq_d.push_back(pd);
        end
        if (!pwe && pa == 7'h09 && drop_rd2) begin
          rd2_den_t = cyc;
        end else begin
          pend  = 1'b1;
          lat_r = $urandom_range(0, 3);
        end
      end
    end
  end

  // PLL model: loses lock in reset, relocks after a random delay
  bit auto_lock;
  int lcnt, lock_dly;

  always @(negedge clk) begin
    if (pll_rst) begin
      locked = 1'b0;
      lcnt   = 0;
    end else if (auto_lock && !locked) begin
      if (lcnt >= lock_dly) locked = 1'b1;
      else lcnt++;
    end
  end

  // Reference divider encoding from H/L/edge/no_count rules
  function automatic logic [15:0] m_reg1(input logic [15:0] rd, input int d);
    int h, l;
    logic [5:0] hv, lv;
    h = d / 2;
    l = d - h;
    if (d == 1) begin
      h = 1;
      l = 1;
    end
    hv = h[5:0];
    lv = l[5:0];
    return {rd[15:12], hv, lv};
  endfunction

  function automatic logic [15:0] m_reg2(input logic [15:0] rd, input int d);
    logic e, nc;
    nc = (d == 1);
    e  = (d % 2 == 1) && (d != 1);
    return {rd[15:8], e, nc, 6'b0};
  endfunction

  task automatic request(input int d, input logic [15:0] r1,
                         input logic [15:0] r2, input bit drop,
                         input bit nolock);
    int  exp_err, lat, fall_t, bound;
    bit  legal, rst_seen;
    legal   = (d >= 1) && (d <= 126);
    exp_err = !legal ? 1 : drop ? 2 : nolock ? 3 : 0;
    mem[8]    = r1;
    mem[9]    = r2;
    drop_rd2  = drop;
    auto_lock = !nolock;
    lock_dly  = $urandom_range(3, 20);
    wq_a.delete();
    wq_d.delete();
    den_cnt = 0;
    viol    = 0;
    fall_t  = -1;
    @(negedge clk);
    cfg_valid = 1'b1;
    cfg_div   = d[7:0];
    bound = 0;
    while (!cfg_ready && bound < 200) begin
      @(negedge clk);
      bound++;
    end
    chk("ready_wait", cfg_ready, 1);
    @(negedge clk);
    cfg_valid = 1'b0;
    cfg_div   = 8'($urandom);
    lat = 1;
    chk("ready_drop", cfg_ready, 0);
    chk("rst_rise", pll_rst, legal);
    rst_seen = pll_rst;
    bound = nolock ? 70000 : 2000;
    while (!done && lat < bound) begin
      @(negedge clk);
      lat++;
      if (pll_rst) rst_seen = 1'b1;
      else if (rst_seen && fall_t < 0) fall_t = cyc;
    end
    chk("done_seen", done, 1);
    chk("err_code", err, exp_err);
    if (!legal) begin
      chk("illegal_done_lat", lat, 2);
      chk("illegal_no_rst", rst_seen, 0);
      chk("illegal_no_den", den_cnt, 0);
    end else if (drop) begin
      chk("drop_den_cnt", den_cnt, 3);
      chk("drop_wr_cnt", wq_d.size(), 1);
      if (wq_d.size() == 1) chk("drop_wr1", wq_d[0], m_reg1(r1, d));
      chk("drop_timing", fall_t - rd2_den_t, 1 + 64 + 16);
    end else begin
      chk("den_cnt", den_cnt, 4);
      chk("wr_cnt", wq_d.size(), 2);
      if (wq_d.size() == 2) begin
        chk("wr1_addr", wq_a[0], 8);
        chk("wr1_data", wq_d[0], m_reg1(r1, d));
        chk("wr2_addr", wq_a[1], 9);
        chk("wr2_data", wq_d[1], m_reg2(r2, d));
      end
      if (!nolock) chk("hold_len", fall_t - last_drdy_t, 17);
      else chk("lock_wait", (lat >= 65536 + 16) && (lat <= 65536 + 200), 1);
    end
    @(negedge clk);
    chk("done_pulse", done, 0);
    chk("ready_back", cfg_ready, 1);
    chk("clk_ok", clk_ok, exp_err != 3);
    chk("drp_stable", viol, 0);
  endtask

  initial begin
    int n, d, bound;
    arst_n    = 1'b0;
    cfg_valid = 1'b0;
    cfg_div   = 8'd0;
    drp_do    = 16'd0;
    drdy      = 1'b0;
    locked    = 1'b0;
    auto_lock = 1'b0;
    drop_rd2  = 1'b0;
    for (int i = 0; i < 128; i++) mem[i] = 16'd0;
    repeat (3) @(negedge clk);
    chk("rst_pll_rst", pll_rst, 1);
    chk("rst_ready", cfg_ready, 0);
    chk("rst_done", done, 0);
    chk("rst_err", err, 0);
    chk("rst_clk_ok", clk_ok, 0);
    chk("rst_den", den, 0);
    chk("rst_dwe", dwe, 0);
    chk("rst_daddr", daddr, 0);
    chk("rst_di", di, 0);

    arst_n = 1'b1;
    n = 0;
    for (int k = 0; k < 20; k++) begin
      if (pll_rst) n++;
      @(negedge clk);
    end
    chk("boot_rst_len", n, 16);
    chk("boot_rst_low", pll_rst, 0);
    locked = 1'b1;
    repeat (3) @(negedge clk);
    chk("boot_clk_ok", clk_ok, 1);
    chk("boot_err", err, 0);
    auto_lock = 1'b1;

    request(10, 16'hF1C3, 16'hAB3F, 0, 0);
    chk("d10_reg1", wq_d.size() > 0 ? int'(wq_d[0]) : -1, 16'hF145);
    chk("d10_reg2", wq_d.size() > 1 ? int'(wq_d[1]) : -1, 16'hAB00);
    request(7, 16'hF1C3, 16'hAB3F, 0, 0);
    chk("d7_reg1", wq_d.size() > 0 ? int'(wq_d[0]) : -1, 16'hF0C4);
    chk("d7_reg2", wq_d.size() > 1 ? int'(wq_d[1]) : -1, 16'hAB80);
    request(1, 16'hF1C3, 16'hAB3F, 0, 0);
    chk("d1_reg1", wq_d.size() > 0 ? int'(wq_d[0]) : -1, 16'hF041);
    chk("d1_reg2", wq_d.size() > 1 ? int'(wq_d[1]) : -1, 16'hAB40);
    request(0, 16'h1234, 16'h5678, 0, 0);
    request(127, 16'h1234, 16'h5678, 0, 0);

    for (int i = 0; i < 8; i++) begin
      if ($urandom_range(0, 5) == 0) d = $urandom_range(127, 255);
      else d = $urandom_range(1, 126);
      request(d, 16'($urandom), 16'($urandom), 0, 0);
    end

    request($urandom_range(1, 126), 16'($urandom), 16'($urandom), 1, 0);
    request($urandom_range(1, 126), 16'($urandom), 16'($urandom), 0, 1);

    @(negedge clk);
    locked = 1'b1;
    repeat (3) @(negedge clk);
    chk("relock_clk_ok", clk_ok, 1);
    auto_lock = 1'b1;

    mem[8] = 16'($urandom);
    mem[9] = 16'($urandom);
    @(negedge clk);
    cfg_valid = 1'b1;
    cfg_div   = 8'd20;
    bound = 0;
    while (!(den && dwe) && bound < 200) begin
      @(negedge clk);
      bound++;
    end
    chk("wr1_reached", den && dwe, 1);
    cfg_valid = 1'b0;
    #2 arst_n = 1'b0;
    #1;
    chk("arst_den", den, 0);
    chk("arst_dwe", dwe, 0);
    chk("arst_pll_rst", pll_rst, 1);
    repeat (2) @(negedge clk);
    arst_n = 1'b1;
    bound = 0;
    while (!clk_ok && bound < 200) begin
      @(negedge clk);
      bound++;
    end
    chk("reboot_clk_ok", clk_ok, 1);
    chk("reboot_err", err, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
